// File: rtl/wide_uart_scheduler.sv
// wide_uart_scheduler
//   Round-robin scheduler sharing one wide_uart link between NUM_REQ clients.
//   Each grant forwards one 64-bit command word to the link, waits for one
//   64-bit response word, and returns it to the granted requester. Only one
//   transaction is outstanding at a time.
//
// Optional feature macro: WIDE_UART_SCHED_TIMEOUT_EN
//   Defined   : a response timeout of TIMEOUT_CYCLES clk cycles in WAIT
//               produces the error word 64'hDEAD_DEAD_DEAD_DEAD with
//               rsp_timeout=1.
//   Undefined : WAIT lasts until a response arrives; rsp_timeout tied to 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_tdata/tvalid/tready   per-requester command stream (64 bits each)
//   rsp_tdata       shared registered response word
//   rsp_tvalid/tready         per-requester response handshake
//   rsp_timeout     presented response is a timeout error word
//   uart_s_*        command stream towards wide_uart s_axis
//   uart_m_*        response stream from wide_uart m_axis
//   grant_id        current or most recent grant
//   busy            scheduler not in IDLE
//   stray_count     saturating count of unsolicited responses dropped
module wide_uart_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [64*NUM_REQ-1:0]      req_tdata,
  input  logic [NUM_REQ-1:0]         req_tvalid,
  output logic [NUM_REQ-1:0]         req_tready,
  output logic [63:0]                rsp_tdata,
  output logic [NUM_REQ-1:0]         rsp_tvalid,
  input  logic [NUM_REQ-1:0]         rsp_tready,
  output logic                       rsp_timeout,
  output logic [63:0]                uart_s_tdata,
  output logic                       uart_s_tvalid,
  input  logic                       uart_s_tready,
  input  logic [63:0]                uart_m_tdata,
  input  logic                       uart_m_tvalid,
  output logic                       uart_m_tready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [7:0]                 stray_count
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("wide_uart_scheduler: NUM_REQ must be 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wide_uart_scheduler: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_q;
  logic [63:0]   rsp_data_q;
  logic [7:0]    stray_q;
  logic          m_rdy_q;

`ifdef WIDE_UART_SCHED_TIMEOUT_EN
  logic [31:0]   to_cnt_q;
  logic          timeout_q;
`endif

  logic [63:0]   req_words [NUM_REQ];
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] arb_cand;
  logic          s_hs;
  logic          m_hs;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_words[g] = req_tdata[g*64 +: 64];
  end

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    arb_cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      arb_cand = IW'((32'(last_q) + i) % NUM_REQ);
      if (!win_found && req_tvalid[arb_cand]) begin
        win_found = 1'b1;
        win_idx   = arb_cand;
      end
    end
  end

  // The command beat only presents valid while the granted requester does,
  // so a requester dropping valid stalls SEND instead of sending stale data.
  always_comb begin
    uart_s_tdata  = req_words[grant_q];
    uart_s_tvalid = (state_q == S_SEND) && req_tvalid[grant_q];
    req_tready    = '0;
    if (state_q == S_SEND) begin
      req_tready[grant_q] = uart_s_tready;
    end
    rsp_tvalid = '0;
    if (state_q == S_RESP) begin
      rsp_tvalid[grant_q] = 1'b1;
    end
  end

  assign s_hs          = uart_s_tvalid && uart_s_tready;
  assign m_hs          = uart_m_tvalid && m_rdy_q;
  assign uart_m_tready = m_rdy_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_q;
  assign rsp_tdata     = rsp_data_q;
  assign stray_count   = stray_q;
`ifdef WIDE_UART_SCHED_TIMEOUT_EN
  assign rsp_timeout   = timeout_q;
`else
  assign rsp_timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      rsp_data_q <= '0;
      stray_q    <= '0;
      m_rdy_q    <= 1'b0;
`ifdef WIDE_UART_SCHED_TIMEOUT_EN
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      // Response channel is always drained so the link never blocks.
      m_rdy_q <= 1'b1;

      // Any response outside WAIT is unsolicited and dropped.
      if (m_hs && (state_q != S_WAIT) && (stray_q != 8'hFF)) begin
        stray_q <= stray_q + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q <= win_idx;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (s_hs) begin
`ifdef WIDE_UART_SCHED_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the expiry cycle takes priority over the timeout.
          if (m_hs) begin
            rsp_data_q <= uart_m_tdata;
`ifdef WIDE_UART_SCHED_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            state_q    <= S_RESP;
          end
`ifdef WIDE_UART_SCHED_TIMEOUT_EN
          else if (to_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            rsp_data_q <= 64'hDEAD_DEAD_DEAD_DEAD;
            timeout_q  <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_tready[grant_q]) begin
            last_q  <= grant_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_uart_scheduler.sv
module tb_wide_uart_scheduler;

`ifdef WIDE_UART_SCHED_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1000000;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] req_tdata = '0;
  logic [3:0]   req_tvalid = '0;
  logic [3:0]   req_tready;
  logic [63:0]  rsp_tdata;
  logic [3:0]   rsp_tvalid;
  logic [3:0]   rsp_tready = '0;
  logic         rsp_timeout;
  logic [63:0]  uart_s_tdata;
  logic         uart_s_tvalid;
  logic         uart_s_tready = 1'b0;
  logic [63:0]  uart_m_tdata = '0;
  logic         uart_m_tvalid = 1'b0;
  logic         uart_m_tready;
  logic [1:0]   grant_id;
  logic         busy;
  logic [7:0]   stray_count;

  wide_uart_scheduler #(
    .NUM_REQ       (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_tdata    (req_tdata),
    .req_tvalid   (req_tvalid),
    .req_tready   (req_tready),
    .rsp_tdata    (rsp_tdata),
    .rsp_tvalid   (rsp_tvalid),
    .rsp_tready   (rsp_tready),
    .rsp_timeout  (rsp_timeout),
    .uart_s_tdata (uart_s_tdata),
    .uart_s_tvalid(uart_s_tvalid),
    .uart_s_tready(uart_s_tready),
    .uart_m_tdata (uart_m_tdata),
    .uart_m_tvalid(uart_m_tvalid),
    .uart_m_tready(uart_m_tready),
    .grant_id     (grant_id),
    .busy         (busy),
    .stray_count  (stray_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned r;
    logic [63:0] cmd;
    logic [63:0] exp;
    int unsigned s_stall;
    int unsigned lat;
    int unsigned r_stall;
  } vec_t;

  typedef struct {
    int unsigned r;
    logic [63:0] d;
    logic        to;
  } sb_t;

  vec_t tbl [4];
  sb_t  sbq [$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop();
    sb_t e;
    if (sbq.size() == 0) begin
      check("sb_unexpected_rsp", 64'(rsp_tvalid), 64'd0);
    end else begin
      e = sbq.pop_front();
      check("rsp_tvalid", 64'(rsp_tvalid), 64'(1) << e.r);
      check("rsp_tdata", rsp_tdata, e.d);
      check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_tvalid = '0;
    rsp_tready = '0;
    uart_s_tready = 1'b0;
    uart_m_tvalid = 1'b0;
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int unsigned n;
    logic [63:0] first;
    logic [63:0] cap;
    req_tdata[v.r*64 +: 64] = v.cmd;
    req_tvalid[v.r] = 1'b1;
    uart_s_tready = 1'b0;
    sbq.push_back('{r: v.r, d: v.exp, to: 1'b0});
    n = 0;
    do begin @(negedge clk); n++; end while (!uart_s_tvalid && n < 20);
    check("send_latency", 64'(n), 64'd1);
    check("grant_id", 64'(grant_id), 64'(v.r));
    first = uart_s_tdata;
    check("s_tdata", first, v.cmd);
    for (int unsigned k = 0; k < v.s_stall; k++) begin
      check("req_tready_stall", 64'(req_tready), 64'd0);
      check("s_tdata_stable", uart_s_tdata, first);
      @(negedge clk);
    end
    check("s_tvalid_held", 64'(uart_s_tvalid), 64'd1);
    uart_s_tready = 1'b1;
    #1;
    check("req_tready", 64'(req_tready), 64'(1) << v.r);
    cap = uart_s_tdata;
    @(negedge clk);
    uart_s_tready = 1'b0;
    req_tvalid[v.r] = 1'b0;
    check("s_tvalid_wait", 64'(uart_s_tvalid), 64'd0);
    check("busy_wait", 64'(busy), 64'd1);
    repeat (v.lat) @(negedge clk);
    uart_m_tdata = ~cap;
    uart_m_tvalid = 1'b1;
    @(negedge clk);
    uart_m_tvalid = 1'b0;
    sb_pop();
    for (int unsigned k = 0; k < v.r_stall; k++) begin
      @(negedge clk);
      check("rsp_tvalid_held", 64'(rsp_tvalid), 64'(1) << v.r);
    end
    rsp_tready[v.r] = 1'b1;
    @(negedge clk);
    rsp_tready = '0;
    check("rsp_tvalid_done", 64'(rsp_tvalid), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  int unsigned rr_order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int unsigned n;
    logic [63:0] cap;

    tbl[0] = '{r: 0, cmd: 64'h0123_4567_89AB_CDEF, exp: 64'hFEDC_BA98_7654_3210, s_stall: 0,  lat: 0, r_stall: 0};
    tbl[1] = '{r: 2, cmd: 64'h0000_0000_FFFF_FFFF, exp: 64'hFFFF_FFFF_0000_0000, s_stall: 10, lat: 3, r_stall: 5};
    tbl[2] = '{r: 3, cmd: 64'hA5A5_A5A5_5A5A_5A5A, exp: 64'h5A5A_5A5A_A5A5_A5A5, s_stall: 2,  lat: 1, r_stall: 1};
    tbl[3] = '{r: 1, cmd: 64'h0000_0000_0000_0000, exp: 64'hFFFF_FFFF_FFFF_FFFF, s_stall: 0,  lat: 5, r_stall: 0};

    // Reset state
    do_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_rsp_tdata", rsp_tdata, 64'd0);
    check("rst_stray", 64'(stray_count), 64'd0);
    check("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
    check("rst_s_tvalid", 64'(uart_s_tvalid), 64'd0);
    check("rst_req_tready", 64'(req_tready), 64'd0);
    check("rst_m_tready", 64'(uart_m_tready), 64'd0);
    check("rst_timeout", 64'(rsp_timeout), 64'd0);

    // Table-driven single transactions, including backpressure
    for (int unsigned i = 0; i < 4; i++) run_txn(tbl[i]);
    check("no_stray_after_table", 64'(stray_count), 64'd0);
    check("sb_drained", 64'(sbq.size()), 64'd0);

    // Stray responses while idle, then saturation
    do_reset();
    @(negedge clk);
    for (int unsigned i = 0; i < 303; i++) begin
      uart_m_tvalid = 1'b1;
      @(negedge clk);
      uart_m_tvalid = 1'b0;
      if (i == 2)   check("stray_3", 64'(stray_count), 64'd3);
      if (i == 254) check("stray_255", 64'(stray_count), 64'd255);
      if (i == 2 || i == 302) check("stray_no_rsp", 64'(rsp_tvalid), 64'd0);
      @(negedge clk);
    end
    check("stray_sat", 64'(stray_count), 64'd255);

    // Round-robin fairness with all requesters valid and an instant link
    do_reset();
    for (int unsigned i = 0; i < 4; i++) req_tdata[i*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    req_tvalid = 4'hF;
    uart_s_tready = 1'b1;
    rsp_tready = 4'hF;
    for (int unsigned k = 0; k < 6; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!uart_s_tvalid && n < 20);
      check(k == 0 ? "rr_first_latency" : "rr_b2b_gap", 64'(n), k == 0 ? 64'd1 : 64'd2);
      check("rr_grant", 64'(grant_id), 64'(rr_order[k]));
      check("rr_s_tdata", uart_s_tdata, 64'h1111_1111_1111_1111 * 64'(rr_order[k] + 1));
      cap = uart_s_tdata;
      sbq.push_back('{r: rr_order[k], d: ~(64'h1111_1111_1111_1111 * 64'(rr_order[k] + 1)), to: 1'b0});
      @(negedge clk);
      uart_m_tdata = ~cap;
      uart_m_tvalid = 1'b1;
      @(negedge clk);
      uart_m_tvalid = 1'b0;
      sb_pop();
      if (k == 5) req_tvalid = '0;
    end
    @(negedge clk);
    check("rr_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of WAIT (last completed grant was 1)
    req_tdata[2*64 +: 64] = 64'hCAFE_F00D_0000_0002;
    req_tvalid = 4'b0100;
    uart_s_tready = 1'b1;
    @(negedge clk);
    check("mid_grant2", 64'(grant_id), 64'd2);
    @(negedge clk);
    check("mid_in_wait", 64'(busy), 64'd1);
    req_tvalid = 4'b0111;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_s_tvalid", 64'(uart_s_tvalid), 64'd0);
    check("arst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    uart_s_tready = 1'b0;
    @(negedge clk);
    check("post_rst_s_tvalid", 64'(uart_s_tvalid), 64'd1);
    check("post_rst_grant0", 64'(grant_id), 64'd0);
    uart_m_tvalid = 1'b1;
    @(negedge clk);
    uart_m_tvalid = 1'b0;
    check("post_rst_stray", 64'(stray_count), 64'd1);
    check("post_rst_no_rsp", 64'(rsp_tvalid), 64'd0);

`ifdef WIDE_UART_SCHED_TIMEOUT_EN
    // Timeout with no response
    do_reset();
    req_tdata[1*64 +: 64] = 64'h1234_0000_0000_0001;
    req_tvalid = 4'b0010;
    uart_s_tready = 1'b1;
    sbq.push_back('{r: 1, d: 64'hDEAD_DEAD_DEAD_DEAD, to: 1'b1});
    @(negedge clk);
    check("to_grant", 64'(grant_id), 64'd1);
    @(negedge clk);
    uart_s_tready = 1'b0;
    req_tvalid = '0;
    n = 0;
    while (rsp_tvalid == '0 && n < 40) begin @(negedge clk); n++; end
    check("to_cycles", 64'(n), 64'd16);
    sb_pop();
    rsp_tready = 4'b0010;
    @(negedge clk);
    rsp_tready = '0;
    uart_m_tvalid = 1'b1;
    @(negedge clk);
    uart_m_tvalid = 1'b0;
    check("to_late_stray", 64'(stray_count), 64'd1);

    // Response in the expiry cycle wins
    req_tdata[1*64 +: 64] = 64'h1234_0000_0000_0002;
    req_tvalid = 4'b0010;
    uart_s_tready = 1'b1;
    sbq.push_back('{r: 1, d: 64'hEDCB_FFFF_FFFF_FFFD, to: 1'b0});
    @(negedge clk);
    @(negedge clk);
    uart_s_tready = 1'b0;
    req_tvalid = '0;
    repeat (15) @(negedge clk);
    check("to_edge_still_wait", 64'(rsp_tvalid), 64'd0);
    uart_m_tdata = 64'hEDCB_FFFF_FFFF_FFFD;
    uart_m_tvalid = 1'b1;
    @(negedge clk);
    uart_m_tvalid = 1'b0;
    sb_pop();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
